sparse_fm_encoder: RTL
======================

# sparse_fm_encoder

Producer side of the non-null value (NNV) stream consumed by the voting convolution block. Scans a dense input feature map (IFM) held in a synchronous RAM in raster order and drops null values. Each surviving value is written compacted into the NNV value memory, and its raster position is written into the reference-address memory. Reports the final non-null count, which the convolution block uses as its FMVALUES bound.

## Interface
- FM_SIZE, `FM_SIZE — IFM side length; N = FM_SIZE**2 positions
- AW, $clog2(FM_SIZE**2) — raster address width (localparam)
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  begin scan; sampled in s_idle and s_done
- o_dense_r_addr  out  AW+1  dense IFM RAM read address (extra bit marks end)
- i_dense_data  in  `A_DSP_WIDTH signed  RAM read data, valid one cycle after address
- o_nnv_w_en  out  1  write strobe for both NNV memories
- o_nnv_w_addr  out  AW  compacted write slot (0,1,2,…)
- o_nnv_data  out  `A_DSP_WIDTH signed  non-null value
- o_ref_data  out  AW  raster position of that value
- o_values  out  AW+1  running, then final, non-null count
- o_done  out  1  scan complete, all writes issued
- Clock and reset: single clock; synchronous, active-high reset `i_rst`.

## Operation
- States: s_idle, s_scan, s_flush, s_done.
- s_idle → s_scan on i_start. On entry to s_scan: o_dense_r_addr=0, o_values=0, o_nnv_w_addr=0.
- s_scan: o_dense_r_addr increments by 1 each cycle through N-1. The address is delayed through a 2-stage pipeline (addr, valid) aligned with the RAM latency.
- Null test on the aligned data: value == 0 (see Configuration). Non-null values produce one registered write:
  - o_nnv_w_en=1
  - o_nnv_data = data
  - o_ref_data = aligned address
  - o_nnv_w_addr = current o_values
  - o_values increments on the same edge
- After issuing address N-1, o_dense_r_addr goes to N (end marker) and the state moves to s_flush. s_flush lasts exactly 2 cycles, draining the pipeline, then the state moves to s_done.
- s_done: o_done=1. o_values holds its value. No writes occur. i_start restarts the scan (→ s_scan, counters cleared, o_done=0). Otherwise the block stays in s_done.
- Null data produces no write. The output write slots are gap-free and strictly increasing. o_ref_data values are strictly increasing.
- Reset values: o_dense_r_addr=0, o_nnv_w_en=0, o_nnv_w_addr=0, o_nnv_data=0, o_ref_data=0, o_values=0, o_done=0, state s_idle, pipeline valid bits cleared.

## Timing
- E0 is the edge that samples i_start in s_idle or s_done.
- o_dense_r_addr = k after edge Ek, for k = 0..N-1. It equals N after EN.
- Write for raster position k is visible after E(k+2) for exactly one cycle.
- The last possible write is visible after E(N+1). o_done=1 after E(N+2). Total latency start→done = N+2 cycles.
- i_start during s_scan or s_flush is ignored.
- i_rst at any point, including mid-scan, takes effect on the next edge: every output returns to its reset value and no further write strobes are issued. Writes already performed are not retracted.
- o_values is stable from the first s_flush cycle after the final write. It is guaranteed final when o_done=1.
- All-null map: no writes, o_values=0, o_done still at E(N+2). All-non-null map: N writes, o_values=N (uses the extra bit).

## Configuration
- `SPARSE_THRESHOLD_EN` defined:
  - adds input i_threshold (`A_DSP_WIDTH unsigned)
  - a value is null when |data| <= i_threshold
  - i_threshold is sampled once at E0 and held for the scan
- Not defined:
  - the port is absent
  - a value is null only when data == 0

## Test plan
- FM_SIZE=4, RAM = 0,5,0,0, 0,0,-3,0, 0,0,0,0, 0,0,0,7, start → three writes:
  - (slot 0, data 5, ref 1) after E3
  - (slot 1, data -3, ref 6) after E8
  - (slot 2, data 7, ref 15) after E17
  - then o_values=3 and o_done after E18.
- All-zero map → no o_nnv_w_en pulses, o_values=0, o_done after E18.
- All-ones map → 16 consecutive write pulses after E2..E17, slots 0..15, refs 0..15; o_values=16.
- Reset asserted at E7 of the first vector → outputs at reset values after E8. No write occurs for ref 6 or ref 15, and o_done stays 0.
- Restart: after done, reload RAM with the single value 9 at position 10 and pulse i_start → o_done drops, one write (slot 0, data 9, ref 10), o_values=1.
- `SPARSE_THRESHOLD_EN`, i_threshold=4, RAM = 3,-5,4,6 then zeros → writes -5 (ref 1) and 6 (ref 3) only; o_values=2.

Source files
------------

// File: rtl/sparse_fm_encoder.sv
// rtl/sparse_fm_encoder.sv - raster scan of a dense IFM into a compacted NNV stream (optional SPARSE_THRESHOLD_EN)

`ifndef A_DSP_WIDTH
`define A_DSP_WIDTH 16
`endif
`ifndef FM_SIZE
`define FM_SIZE 4
`endif

module sparse_fm_encoder #(
  parameter int FM_SIZE = `FM_SIZE,
  localparam int AW = $clog2(FM_SIZE * FM_SIZE)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  output logic [AW:0]                    o_dense_r_addr,
  input  logic signed [`A_DSP_WIDTH-1:0] i_dense_data,
`ifdef SPARSE_THRESHOLD_EN
  input  logic [`A_DSP_WIDTH-1:0]        i_threshold,
`endif
  output logic                           o_nnv_w_en,
  output logic [AW-1:0]                  o_nnv_w_addr,
  output logic signed [`A_DSP_WIDTH-1:0] o_nnv_data,
  output logic [AW-1:0]                  o_ref_data,
  output logic [AW:0]                    o_values,
  output logic                           o_done
);

  localparam int N  = FM_SIZE * FM_SIZE;
  localparam int W  = `A_DSP_WIDTH;
  localparam int VW = AW + 1;
  localparam logic [AW:0] LAST_ADDR = VW'(N - 1);

  typedef enum logic [1:0] {
    s_idle,
    s_scan,
    s_flush,
    s_done
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic          flush_q;
  logic          start_scan;
  logic          p_valid;
  logic [AW-1:0] p_addr;
  logic          is_null;

`ifdef SPARSE_THRESHOLD_EN
  logic [W-1:0]  thr_q;
  logic [W-1:0]  abs_val;

  // Magnitude compare against the threshold captured at scan start
  always_comb begin
    abs_val = i_dense_data[W-1] ? W'(-i_dense_data) : W'(i_dense_data);
    is_null = (abs_val <= thr_q);
  end
`else
  // Only an exact zero is dropped
  always_comb begin
    is_null = (i_dense_data == '0);
  end
`endif

  // Next-state logic; start is only honoured while idle or done
  always_comb begin
    state_d    = state_q;
    start_scan = 1'b0;
    case (state_q)
      s_idle: begin
        if (i_start) begin
          state_d    = s_scan;
          start_scan = 1'b1;
        end
      end
      s_scan: begin
        if (o_dense_r_addr == LAST_ADDR) state_d = s_flush;
      end
      s_flush: begin
        if (flush_q) state_d = s_done;
      end
      s_done: begin
        if (i_start) begin
          state_d    = s_scan;
          start_scan = 1'b1;
        end
      end
      default: state_d = s_idle;
    endcase
  end

  // State register plus the two-cycle flush timer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= s_idle;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= (state_q == s_flush) && !flush_q;
    end
  end

  // Address generation, RAM-latency alignment and compacted write issue
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_dense_r_addr <= '0;
      o_nnv_w_en     <= 1'b0;
      o_nnv_w_addr   <= '0;
      o_nnv_data     <= '0;
      o_ref_data     <= '0;
      o_values       <= '0;
      o_done         <= 1'b0;
      p_valid        <= 1'b0;
      p_addr         <= '0;
`ifdef SPARSE_THRESHOLD_EN
      thr_q          <= '0;
`endif
    end else begin
      o_nnv_w_en <= 1'b0;
      // Address issued this cycle lines up with RAM data one edge later
      p_valid    <= (state_q == s_scan);
      p_addr     <= o_dense_r_addr[AW-1:0];
      o_done     <= (state_d == s_done);

      if (start_scan) begin
        o_dense_r_addr <= '0;
        o_values       <= '0;
        o_nnv_w_addr   <= '0;
`ifdef SPARSE_THRESHOLD_EN
        thr_q          <= i_threshold;
`endif
      end else if (state_q == s_scan) begin
        // Runs one past the last position so N marks the end of the map
        o_dense_r_addr <= o_dense_r_addr + VW'(1);
      end

      // p_valid is never set while a start is accepted, so no overlap here
      if (p_valid && !is_null) begin
        o_nnv_w_en   <= 1'b1;
        o_nnv_data   <= i_dense_data;
        o_ref_data   <= p_addr;
        o_nnv_w_addr <= o_values[AW-1:0];
        o_values     <= o_values + VW'(1);
      end
    end
  end

endmodule
